// File: rtl/vga_line_buffer.sv
// ---------------------------------------------------------------------------
// vga_line_buffer
//   Double-banked scanline buffer between a pixel generator (writer) and the
//   VGA timing block (reader). The writer fills one bank with a complete line
//   while the other bank is scanned out. Each hsync_pulse tries to hand the
//   oldest completed line to the display side; vsync_pulse restarts the
//   per-line repeat count so every frame begins with a swap.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   wr_valid        writer pixel valid
//   wr_data         writer pixel value
//   wr_ready        buffer accepts wr_data this cycle
//   line_req        1-cycle pulse: a bank was freed (or swapped in)
//   advance         pixel advance from the timing block
//   blank           blanking from the timing block
//   hsync_pulse     one pulse per active line, during hsync
//   vsync_pulse     one pulse per frame, after vsync
//   pix_data        registered display pixel (lags timing by one advance)
//   underrun        sticky: a line swap failed after the first good swap
//
// Write handshake: a pixel is transferred on every rising clk edge where
// wr_valid && wr_ready. wr_ready depends only on internal state, never on
// wr_valid, and the writer must hold wr_data stable while wr_valid && !wr_ready.
// ---------------------------------------------------------------------------
module vga_line_buffer #(
  parameter int                 LINE_PIXELS     = 720,
  parameter int                 DATA_W          = 6,
  parameter int                 LINE_REPEAT     = 1,
  parameter logic [DATA_W-1:0]  UNDERRUN_COLOUR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              line_req,
  input  logic              advance,
  input  logic              blank,
  input  logic              hsync_pulse,
  input  logic              vsync_pulse,
  output logic [DATA_W-1:0] pix_data,
  output logic              underrun
);

  localparam int               PTR_W    = $clog2(LINE_PIXELS + 1);
  localparam int               ADDR_W   = $clog2(2 * LINE_PIXELS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_PIXELS - 1);
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(LINE_PIXELS);
  localparam logic [3:0]       REP_INIT = 4'(LINE_REPEAT - 1);

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_DISPLAY = 2'd3
  } bank_state_t;

  // Per-bank lifecycle FSM state; kept as named signals so checkers can bind.
  bank_state_t bank_state      [2];
  bank_state_t bank_state_next [2];

  logic [DATA_W-1:0] mem [2*LINE_PIXELS];

  logic              wr_bank;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        rep_cnt;
  logic              started;

  logic              wr_fire;
  logic              wr_last;
  logic              disp_valid;
  logic              disp_bank;
  logic              full_any;
  logic              full_bank;
  logic [3:0]        rep_eff;
  logic              swap_eval;
  logic              do_swap;
  logic              do_release;
  logic              rd_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // ---------------- derived control ----------------
  always_comb begin
    wr_fire     = wr_valid && wr_ready;
    wr_last     = wr_fire && (wr_ptr == PTR_LAST);
    disp_valid  = (bank_state[0] == BANK_DISPLAY) || (bank_state[1] == BANK_DISPLAY);
    disp_bank   = (bank_state[1] == BANK_DISPLAY);
    full_any    = (bank_state[0] == BANK_FULL) || (bank_state[1] == BANK_FULL);
    // When both banks are full, the one the writer has wrapped back to is the
    // older line, so it is shown first.
    full_bank   = (bank_state[wr_bank] == BANK_FULL) ? wr_bank : ~wr_bank;
    // A vsync in the same cycle clears the repeat count before the swap test.
    rep_eff     = vsync_pulse ? 4'd0 : rep_cnt;
    swap_eval   = hsync_pulse && (rep_eff == 4'd0);
    do_swap     = swap_eval && full_any;
    do_release  = swap_eval && disp_valid;
    rd_in_range = disp_valid && (rd_ptr != PTR_END);
    wr_addr     = wr_bank   ? ADDR_W'(LINE_PIXELS) + ADDR_W'(wr_ptr) : ADDR_W'(wr_ptr);
    rd_addr     = disp_bank ? ADDR_W'(LINE_PIXELS) + ADDR_W'(rd_ptr) : ADDR_W'(rd_ptr);
  end

  // ---------------- bank FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_state[0] <= BANK_FREE;
      bank_state[1] <= BANK_FREE;
    end else begin
      bank_state[0] <= bank_state_next[0];
      bank_state[1] <= bank_state_next[1];
    end
  end

  // ---------------- bank FSM: next state ----------------
  // The writer's bank is never FULL or DISPLAY while it is being written, so
  // write and swap updates never target the same bank in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_next[b] = bank_state[b];
      if (wr_fire && (wr_bank == 1'(b)))
        bank_state_next[b] = wr_last ? BANK_FULL : BANK_FILLING;
      if (swap_eval && (bank_state[b] == BANK_DISPLAY))
        bank_state_next[b] = BANK_FREE;
      if (do_swap && (full_bank == 1'(b)))
        bank_state_next[b] = BANK_DISPLAY;
    end
  end

  // ---------------- bank FSM: outputs ----------------
  always_comb begin
    wr_ready = (bank_state[wr_bank] == BANK_FREE) || (bank_state[wr_bank] == BANK_FILLING);
  end

  // ---------------- line memory write port ----------------
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_addr] <= wr_data;
  end

  // ---------------- write pointer, swap control, read side ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rep_cnt  <= 4'd0;
      started  <= 1'b0;
      underrun <= 1'b0;
      line_req <= 1'b0;
      pix_data <= UNDERRUN_COLOUR;
    end else begin
      line_req <= do_swap || do_release;

      if (wr_fire) begin
        if (wr_ptr == PTR_LAST) begin
          wr_ptr  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      if (hsync_pulse) begin
        if (rep_eff == 4'd0) begin
          if (full_any) begin
            started <= 1'b1;
            rep_cnt <= REP_INIT;
          end else begin
            rep_cnt <= 4'd0;
            if (started)
              underrun <= 1'b1;
          end
        end else begin
          rep_cnt <= rep_eff - 4'd1;
        end
      end else if (vsync_pulse) begin
        rep_cnt <= 4'd0;
      end

      // Synchronous read: pix_data is the memory output register.
      if (advance) begin
        if (blank || !rd_in_range)
          pix_data <= UNDERRUN_COLOUR;
        else
          pix_data <= mem[rd_addr];
      end

      if (hsync_pulse)
        rd_ptr <= '0;
      else if (advance && !blank && (rd_ptr != PTR_END))
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_vga_line_buffer
//   Self-checking bench for vga_line_buffer (720-pixel lines, RGB222,
//   LINE_REPEAT=2, underrun colour 6'h2A so it differs from pixel 0).
//   A hsync_pulse issued together with vsync_pulse always swaps, which gives
//   single-repeat behaviour on demand; plain hsync_pulse exercises repeats.
//   Lines are described by {seed, step}: pixel i = (seed + step*i) mod 64.
//   The reference model tracks lines as queues of descriptors and compares
//   every output on every falling edge; directed checks add fixed values.
// ---------------------------------------------------------------------------
module tb_vga_line_buffer;

  localparam int         LP  = 720;
  localparam int         DW  = 6;
  localparam int         LR  = 2;
  localparam logic [5:0] UC  = 6'h2A;

  logic          clk;
  logic          reset;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          line_req;
  logic          advance;
  logic          blank;
  logic          hsync_pulse;
  logic          vsync_pulse;
  logic [DW-1:0] pix_data;
  logic          underrun;

  vga_line_buffer #(
    .LINE_PIXELS     (LP),
    .DATA_W          (DW),
    .LINE_REPEAT     (LR),
    .UNDERRUN_COLOUR (UC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .line_req    (line_req),
    .advance     (advance),
    .blank       (blank),
    .hsync_pulse (hsync_pulse),
    .vsync_pulse (vsync_pulse),
    .pix_data    (pix_data),
    .underrun    (underrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int seed;
    int step;
  } line_t;

  int n_cmp;
  int n_err;

  line_t wline[$];      // lines the writer still has to deliver (head = current)
  line_t m_full_q[$];   // completed lines, oldest first
  line_t m_disp;
  bit    m_disp_v;
  int    m_fill_cnt;
  int    m_rd;
  int    m_rep;
  bit    m_started;
  bit    m_ur;
  bit    m_lr;
  logic [5:0] m_pix;

  function automatic logic [5:0] pix_of(input line_t d, input int i);
    return 6'((d.seed + d.step * i) & 63);
  endfunction

  // A bank is free for the writer if it is mid-line, or fewer than two lines
  // are held (completed + on display).
  function automatic bit m_ready();
    return (m_fill_cnt > 0) || ((m_full_q.size() + int'(m_disp_v)) < 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wline.delete();
    m_full_q.delete();
    m_disp_v   = 0;
    m_fill_cnt = 0;
    m_rd       = 0;
    m_rep      = 0;
    m_started  = 0;
    m_ur       = 0;
    m_lr       = 0;
    m_pix      = UC;
  endtask

  task automatic model_step(input logic wv, input logic adv, input logic blk,
                            input logic hs, input logic vs);
    bit wr_ok;
    int eff;
    wr_ok = wv && m_ready();
    if (adv) begin
      if (blk) begin
        m_pix = UC;
      end else begin
        m_pix = (m_disp_v && m_rd < LP) ? pix_of(m_disp, m_rd) : UC;
        if (m_rd < LP) m_rd++;
      end
    end
    m_lr = 0;
    eff  = vs ? 0 : m_rep;
    if (hs) begin
      m_rd = 0;
      if (eff == 0) begin
        if (m_full_q.size() > 0) begin
          m_disp    = m_full_q.pop_front();
          m_disp_v  = 1;
          m_lr      = 1;
          m_started = 1;
          m_rep     = LR - 1;
        end else begin
          if (m_disp_v) m_lr = 1;
          m_disp_v = 0;
          if (m_started) m_ur = 1;
          m_rep = 0;
        end
      end else begin
        m_rep = eff - 1;
      end
    end else if (vs) begin
      m_rep = 0;
    end
    // A line finishing now only becomes visible to later hsyncs.
    if (wr_ok) begin
      m_fill_cnt++;
      if (m_fill_cnt == LP) begin
        m_full_q.push_back(wline.pop_front());
        m_fill_cnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("pix_data", 32'(pix_data), 32'(m_pix));
    check("wr_ready", 32'(wr_ready), 32'(m_ready()));
    check("line_req", 32'(line_req), 32'(m_lr));
    check("underrun", 32'(underrun), 32'(m_ur));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic adv, input logic blk, input logic hs,
                       input logic vs, input logic wv);
    advance     = adv;
    blank       = blk;
    hsync_pulse = hs;
    vsync_pulse = vs;
    if (wv && wline.size() > 0) begin
      wr_valid = 1'b1;
      wr_data  = pix_of(wline[0], m_fill_cnt);
    end else begin
      wr_valid = 1'b0;
      wr_data  = 6'($urandom_range(0, 63));
    end
    @(posedge clk);
    @(negedge clk);
    model_step(wr_valid, adv, blk, hs, vs);
    compare_all();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = '0;
    advance     = 1'b0;
    blank       = 1'b0;
    hsync_pulse = 1'b0;
    vsync_pulse = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  task automatic push_line(input int seed, input int step);
    line_t d;
    d.seed = seed;
    d.step = step;
    wline.push_back(d);
  endtask

  task automatic push_rand_line();
    push_line(int'($urandom_range(0, 63)), int'($urandom_range(1, 63)));
  endtask

  // Write until the model has accepted n pixels of the current line stream.
  task automatic write_pixels(input int n);
    int done;
    done = 0;
    for (int k = 0; k < 4 * LP && done < n; k++) begin
      if (m_ready()) done++;
      cycle(0, 0, 0, 0, 1);
    end
    check("write_budget", 32'(done), 32'(n));
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic       adv;
    logic       blk;
    logic       hs;
    logic       vs;
    logic [5:0] pix;
    logic       lr;
    logic       ur;
  } vec_t;

  vec_t tbl[7];
  line_t la, lb;

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Start of line-0 scan-out (pixels i%64): swap, reads, hold, blanked advance.
    tbl[0] = '{adv:1'b0, blk:1'b0, hs:1'b1, vs:1'b1, pix:UC,    lr:1'b1, ur:1'b0};
    tbl[1] = '{adv:1'b1, blk:1'b0, hs:1'b0, vs:1'b0, pix:6'd0,  lr:1'b0, ur:1'b0};
    tbl[2] = '{adv:1'b1, blk:1'b0, hs:1'b0, vs:1'b0, pix:6'd1,  lr:1'b0, ur:1'b0};
    tbl[3] = '{adv:1'b0, blk:1'b0, hs:1'b0, vs:1'b0, pix:6'd1,  lr:1'b0, ur:1'b0};
    tbl[4] = '{adv:1'b1, blk:1'b1, hs:1'b0, vs:1'b0, pix:UC,    lr:1'b0, ur:1'b0};
    tbl[5] = '{adv:1'b1, blk:1'b0, hs:1'b0, vs:1'b0, pix:6'd2,  lr:1'b0, ur:1'b0};
    tbl[6] = '{adv:1'b1, blk:1'b0, hs:1'b0, vs:1'b0, pix:6'd3,  lr:1'b0, ur:1'b0};

    // Reset state.
    do_reset();
    check("rst_pix", 32'(pix_data), 32'(UC));
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_lr", 32'(line_req), 32'd0);
    check("rst_ur", 32'(underrun), 32'd0);

    // Line of i%64, swap, scan-out.
    push_line(0, 1);
    write_pixels(LP);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].adv, tbl[i].blk, tbl[i].hs, tbl[i].vs, 0);
      check("tbl_pix", 32'(pix_data), 32'(tbl[i].pix));
      check("tbl_lr", 32'(line_req), 32'(tbl[i].lr));
      check("tbl_ur", 32'(underrun), 32'(tbl[i].ur));
    end
    for (int i = 4; i < LP; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("t1_pix", 32'(pix_data), 32'(i % 64));
    end
    cycle(1, 0, 0, 0, 0);
    check("t1_past_end", 32'(pix_data), 32'(UC));

    // hsync with no full line after a good line.
    cycle(0, 0, 1, 1, 0);
    check("t2_ur_set", 32'(underrun), 32'd1);
    check("t2_lr", 32'(line_req), 32'd1);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("t2_pix", 32'(pix_data), 32'(UC));
    end
    push_rand_line();
    write_pixels(LP);
    cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    check("t2_ur_sticky", 32'(underrun), 32'd1);

    // Line repeat = 2: swaps only on every second hsync.
    do_reset();
    push_rand_line();
    push_rand_line();
    la = wline[0];
    lb = wline[1];
    write_pixels(LP);
    cycle(0, 0, 1, 1, 0);
    check("t3_lr_h1", 32'(line_req), 32'd1);
    write_pixels(LP);
    cycle(0, 0, 1, 0, 0);
    check("t3_lr_h2", 32'(line_req), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check("t3_repeat_a", 32'(pix_data), 32'(pix_of(la, 0)));
    cycle(0, 0, 1, 0, 0);
    check("t3_lr_h3", 32'(line_req), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check("t3_show_b", 32'(pix_data), 32'(pix_of(lb, 0)));
    cycle(0, 0, 1, 0, 0);
    check("t3_lr_h4", 32'(line_req), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check("t3_repeat_b", 32'(pix_data), 32'(pix_of(lb, 0)));
    check("t3_ur", 32'(underrun), 32'd0);

    // Both banks filled with wr_valid held.
    do_reset();
    push_rand_line();
    push_rand_line();
    push_rand_line();
    for (int i = 0; i < 2 * LP + 20; i++) cycle(0, 0, 0, 0, 1);
    check("t4_stall", 32'(wr_ready), 32'd0);
    check("t4_held", 32'(wline.size()), 32'd1);
    cycle(0, 0, 1, 1, 0);
    check("t4_first_swap", 32'(wr_ready), 32'd0);
    cycle(0, 0, 1, 1, 0);
    check("t4_second_swap", 32'(wr_ready), 32'd1);

    // Last write coincides with hsync: that line is not eligible yet.
    do_reset();
    push_rand_line();
    push_rand_line();
    write_pixels(LP);
    cycle(0, 0, 1, 1, 0);
    lb = wline[0];
    write_pixels(LP - 1);
    cycle(0, 0, 1, 1, 1);
    check("t5_fill_done", 32'(m_full_q.size()), 32'd1);
    check("t5_ur", 32'(underrun), 32'd1);
    check("t5_lr", 32'(line_req), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check("t5_no_disp", 32'(pix_data), 32'(UC));
    cycle(0, 0, 1, 1, 0);
    check("t5_lr_swap", 32'(line_req), 32'd1);
    cycle(1, 0, 0, 0, 0);
    check("t5_pix", 32'(pix_data), 32'(pix_of(lb, 0)));

    // Reset mid-line (300 pixels written) with underrun already set.
    push_rand_line();
    write_pixels(300);
    do_reset();
    check("t6_pix", 32'(pix_data), 32'(UC));
    check("t6_ready", 32'(wr_ready), 32'd1);
    check("t6_lr", 32'(line_req), 32'd0);
    check("t6_ur", 32'(underrun), 32'd0);
    push_rand_line();
    la = wline[0];
    write_pixels(LP);
    cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("t6_line", 32'(pix_data), 32'(pix_of(la, i)));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int ln = 0; ln < 12; ln++) begin
      for (int c = 0; c < 900; c++) begin
        logic hs, vs;
        if (wline.size() < 2) push_rand_line();
        hs = (c == 899);
        vs = hs && ($urandom_range(0, 3) == 0);
        cycle(logic'($urandom_range(0, 15) != 0), logic'(c >= 760), hs, vs,
              logic'($urandom_range(0, 3) != 0));
      end
    end

    wr_valid    = 1'b0;
    advance     = 1'b0;
    hsync_pulse = 1'b0;
    vsync_pulse = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
